cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Collects completed results from NUM_FU functional units and serializes them onto the single Common Data Bus, one broadcast per cycle. Each FU pushes EX_PACKETs into its own small FIFO; a round-robin arbiter selects one FIFO head per cycle and loads it into a registered output that drives the CDB packet-formation logic (ex_packet_in / ex_no_output). Sits between the execute-stage FUs and the CDB; handles back-pressure to FUs and branch-mispredict squash.

## Interface
- NUM_FU, 4: number of requesting functional units (2..8).
- BUF_DEPTH, 2: per-FU FIFO entries; power of two, ≥2.

- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- squash  input  1  synchronous flush (mispredict recovery).
- fu_valid  input  NUM_FU  FU i presents a completed result.
- fu_packet  input  NUM_FU x EX_PACKET  result packets, index i per FU.
- fu_no_output  input  NUM_FU  FU i result writes no register (e.g. store).
- fu_ready  output  NUM_FU  FIFO i can accept this cycle.
- cdb_ex_packet  output  EX_PACKET  packet to broadcast this cycle.
- cdb_ex_no_output  output  1  1 = no register broadcast this cycle.
- cdb_out_valid  output  1  a completion is being broadcast this cycle.

## Operation
- Per-FU FIFO stores {EX_PACKET, no_output}; read/write pointers log2(BUF_DEPTH)+1 bits, wrap modulo 2·BUF_DEPTH; full when indices equal and MSBs differ.
- fu_ready[i] = !full[i], from registered state only (no same-cycle pop credit).
- Push: fu_valid[i] && fu_ready[i] at edge. fu_valid[i] while !fu_ready[i]: ignored, FU must hold.
- Arbitration each cycle over FIFOs non-empty at cycle start (packets pushed this cycle not eligible until next cycle).
- Round-robin: search from rr_ptr upward, wrap at NUM_FU; first non-empty wins; pop head; rr_ptr <= (winner+1) mod NUM_FU. No candidate: rr_ptr unchanged.
- Output register on grant: cdb_ex_packet <= head packet, cdb_out_valid <= 1, cdb_ex_no_output <= head.no_output. No grant: cdb_out_valid <= 0, cdb_ex_no_output <= 1, cdb_ex_packet holds old value (don't care).
- Push and pop on the same FIFO same edge: both occur, occupancy unchanged.
- squash at edge: all FIFOs emptied, pushes that edge dropped, output register invalidated (cdb_out_valid 0, cdb_ex_no_output 1), rr_ptr <= 0. Squash overrides push and grant.

## Timing
- Reset values: all FIFOs empty, rr_ptr 0, cdb_ex_packet all zero, cdb_out_valid 0, cdb_ex_no_output 1, fu_ready all 1.
- Reset asserted mid-operation: state cleared asynchronously, pending results lost; fu_ready returns to 1 immediately.
- Latency: packet accepted at edge N is broadcast earliest in cycle N+1 → N+2 (visible after edge N+1); worst case adds (NUM_FU-1) cycles of round-robin wait per packet ahead.
- Throughput: one broadcast per cycle whenever any FIFO is non-empty.
- Outputs are purely registered; no combinational path from fu_* to cdb_*.

## Configuration
- CDB_ARB_STATS_EN defined: adds outputs stall_cycles (32) and grant_count (32). stall_cycles increments each cycle any fu_valid[i] && !fu_ready[i]; grant_count increments each grant; both saturate at 32'hFFFF_FFFF, clear on reset, unaffected by squash.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Single FU: FU0 valid one cycle (dest 5, alu_result 0x1234) at edge 1 → cdb_out_valid 1, cdb_ex_packet.alu_result 0x1234, cdb_ex_no_output 0 after edge 2; idle after edge 3 with cdb_ex_no_output 1.
- Contention: FU0..FU3 valid same edge, rr_ptr 0 → grants in order 0,1,2,3 on four consecutive edges; rr_ptr ends at 0.
- Back-pressure: FU2 valid every cycle while FU0,FU1 continuously fed → FIFO2 fills (BUF_DEPTH=2), fu_ready[2]=0, held packet not duplicated or lost; order of FU2 outputs matches push order.
- no_output: FU1 pushes store with fu_no_output 1 → cdb_out_valid 1, cdb_ex_no_output 1 in broadcast cycle.
- Squash: FIFOs hold 3 packets, squash with new fu_valid same edge → next cycle all fu_ready 1, cdb_out_valid 0, no further broadcasts; rr_ptr 0.
- Async reset mid-stream: reset pulse between edges → outputs take reset values before next edge; with CDB_ARB_STATS_EN, counters read 0.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: FU-side request bus and CDB-side result bus of the CDB arbiter.
// Also carries the shared EX_PACKET type in cdb_arbiter_pkg.
// Optional macro CDB_ARB_STATS_EN adds the stall_cycles / grant_count signals.

package cdb_arbiter_pkg;
    typedef struct packed {
        logic [5:0]  rob_idx;
        logic [4:0]  dest;
        logic [31:0] alu_result;
    } ex_packet_t;
endpackage

interface cdb_arbiter_if #(
    parameter int unsigned NUM_FU = 4
);
    import cdb_arbiter_pkg::*;

    logic [NUM_FU-1:0] fu_valid;
    ex_packet_t        fu_packet [NUM_FU];
    logic [NUM_FU-1:0] fu_no_output;
    logic [NUM_FU-1:0] fu_ready;
    ex_packet_t        cdb_ex_packet;
    logic              cdb_ex_no_output;
    logic              cdb_out_valid;
`ifdef CDB_ARB_STATS_EN
    logic [31:0]       stall_cycles;
    logic [31:0]       grant_count;
`endif

    // Functional-unit / testbench side
    modport master (
        output fu_valid, fu_packet, fu_no_output,
        input  fu_ready, cdb_ex_packet, cdb_ex_no_output, cdb_out_valid
`ifdef CDB_ARB_STATS_EN
        , input stall_cycles, grant_count
`endif
    );

    // Arbiter side
    modport slave (
        input  fu_valid, fu_packet, fu_no_output,
        output fu_ready, cdb_ex_packet, cdb_ex_no_output, cdb_out_valid
`ifdef CDB_ARB_STATS_EN
        , output stall_cycles, grant_count
`endif
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU result FIFOs feeding a round-robin arbiter that loads one
// completion per cycle into a registered Common Data Bus output.
// Optional macro CDB_ARB_STATS_EN adds saturating stall/grant counters.

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU    = 4,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         squash,
    cdb_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(BUF_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        ex_packet_t pkt;
        logic       no_output;
    } entry_t;

    entry_t            mem_q [NUM_FU][BUF_DEPTH];
    logic [PTR_W-1:0]  wr_q  [NUM_FU];
    logic [PTR_W-1:0]  wr_d  [NUM_FU];
    logic [PTR_W-1:0]  rd_q  [NUM_FU];
    logic [PTR_W-1:0]  rd_d  [NUM_FU];
    logic [RR_W-1:0]   rr_q, rr_d;

    logic [NUM_FU-1:0] empty, full, push, pop;
    logic              grant;
    logic [RR_W-1:0]   winner;
    logic [RR_W-1:0]   cand;
    entry_t            head;

    ex_packet_t        pkt_q;
    logic              valid_q;
    logic              no_out_q;

    // FIFO status from registered pointers only
    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            empty[i] = (wr_q[i] == rd_q[i]);
            full[i]  = (wr_q[i][IDX_W-1:0] == rd_q[i][IDX_W-1:0]) &&
                       (wr_q[i][PTR_W-1] != rd_q[i][PTR_W-1]);
        end
    end

    assign bus.fu_ready = ~full;

    // Round-robin pick: first non-empty FIFO at or after rr_q, wrapping at NUM_FU
    always_comb begin
        grant  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            cand = RR_W'((32'(rr_q) + k) % NUM_FU);
            if (!grant && !empty[cand]) begin
                grant  = 1'b1;
                winner = cand;
            end
        end
        head = mem_q[winner][rd_q[winner][IDX_W-1:0]];
        rr_d = rr_q;
        if (squash) begin
            rr_d = '0;
        end else if (grant) begin
            rr_d = (winner == RR_W'(NUM_FU - 1)) ? '0 : winner + 1'b1;
        end
    end

    // Push/pop decode and next pointers; squash empties every FIFO
    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            push[i] = bus.fu_valid[i] && !full[i] && !squash;
            pop[i]  = grant && (winner == RR_W'(i)) && !squash;
            wr_d[i] = wr_q[i] + PTR_W'(push[i]);
            rd_d[i] = rd_q[i] + PTR_W'(pop[i]);
            if (squash) begin
                wr_d[i] = '0;
                rd_d[i] = '0;
            end
        end
    end

    // Pointer and round-robin state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q <= '{default: '0};
            rd_q <= '{default: '0};
            rr_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            rr_q <= rr_d;
        end
    end

    // FIFO storage; contents are meaningless while pointers say empty
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                mem_q[i][wr_q[i][IDX_W-1:0]] <= '{pkt: bus.fu_packet[i],
                                                  no_output: bus.fu_no_output[i]};
            end
        end
    end

    // Registered CDB output: load granted head, otherwise broadcast nothing
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_q    <= '0;
            valid_q  <= 1'b0;
            no_out_q <= 1'b1;
        end else if (!squash && grant) begin
            pkt_q    <= head.pkt;
            valid_q  <= 1'b1;
            no_out_q <= head.no_output;
        end else begin
            valid_q  <= 1'b0;
            no_out_q <= 1'b1;
        end
    end

    assign bus.cdb_ex_packet    = pkt_q;
    assign bus.cdb_out_valid    = valid_q;
    assign bus.cdb_ex_no_output = no_out_q;

`ifdef CDB_ARB_STATS_EN
    logic [31:0] stall_q;
    logic [31:0] gcnt_q;

    // Saturating counters; squash does not touch them
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            gcnt_q  <= '0;
        end else begin
            if ((|(bus.fu_valid & full)) && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (grant && !squash && (gcnt_q != '1)) begin
                gcnt_q <= gcnt_q + 32'd1;
            end
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.grant_count  = gcnt_q;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and random stimulus for cdb_arbiter, checked against a
// queue-based reference model. Stats checks follow CDB_ARB_STATS_EN.

module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NUM_FU    = 4;
    localparam int BUF_DEPTH = 2;

    logic clock = 1'b0;
    logic reset;
    logic squash;

    int n_tests = 0;
    int n_fail  = 0;

    cdb_arbiter_if #(.NUM_FU(NUM_FU)) bus ();

    cdb_arbiter #(.NUM_FU(NUM_FU), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clock  (clock),
        .reset  (reset),
        .squash (squash),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        ex_packet_t pkt;
        logic       no;
    } ment_t;

    // Reference model: one queue per FU, round-robin pointer, output register
    ment_t       mq [NUM_FU][$];
    int          m_rr;
    logic        m_valid;
    logic        m_no;
    ex_packet_t  m_pkt;
    int unsigned m_stall;
    int unsigned m_gcnt;
    logic [NUM_FU-1:0] accepted;

    // Per-FU driver state
    logic [NUM_FU-1:0] drv_v;
    logic [NUM_FU-1:0] drv_no;
    ex_packet_t        drv_pkt [NUM_FU];
    int unsigned       seq = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_FU-1:0] model_ready();
        logic [NUM_FU-1:0] r;
        for (int i = 0; i < NUM_FU; i++) r[i] = (mq[i].size() < BUF_DEPTH);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_FU; i++) mq[i].delete();
        m_rr = 0; m_valid = 1'b0; m_no = 1'b1; m_pkt = '0;
        m_stall = 0; m_gcnt = 0; accepted = '0;
    endtask

    task automatic model_edge(input logic sq);
        logic [NUM_FU-1:0] r;
        int win;
        ment_t e;
        r = model_ready();
        win = -1;
        accepted = '0;
        if ((drv_v & ~r) != '0) m_stall++;
        if (sq) begin
            for (int i = 0; i < NUM_FU; i++) mq[i].delete();
            m_rr = 0; m_valid = 1'b0; m_no = 1'b1;
        end else begin
            for (int k = 0; k < NUM_FU; k++) begin
                int j;
                j = (m_rr + k) % NUM_FU;
                if (win < 0 && mq[j].size() > 0) win = j;
            end
            if (win >= 0) begin
                e = mq[win].pop_front();
                m_pkt = e.pkt; m_no = e.no; m_valid = 1'b1;
                m_rr = (win + 1) % NUM_FU;
                m_gcnt++;
            end else begin
                m_valid = 1'b0; m_no = 1'b1;
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (drv_v[i] && r[i]) begin
                    mq[i].push_back('{pkt: drv_pkt[i], no: drv_no[i]});
                    accepted[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic new_pkt(input int i);
        drv_pkt[i] = '{rob_idx: 6'(seq), dest: 5'(i), alu_result: $urandom};
        seq++;
    endtask

    task automatic apply();
        bus.fu_valid     = drv_v;
        bus.fu_no_output = drv_no;
        for (int i = 0; i < NUM_FU; i++) bus.fu_packet[i] = drv_pkt[i];
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_valid"}, 64'(bus.cdb_out_valid), 64'(m_valid));
        check({tag, "_noout"}, 64'(bus.cdb_ex_no_output), 64'(m_no));
        if (m_valid) check({tag, "_pkt"}, 64'(bus.cdb_ex_packet), 64'(m_pkt));
`ifdef CDB_ARB_STATS_EN
        check({tag, "_stall"}, 64'(bus.stall_cycles), 64'(m_stall));
        check({tag, "_gcnt"}, 64'(bus.grant_count), 64'(m_gcnt));
`endif
    endtask

    // One clock: drive, check ready mid-cycle, advance model, check after edge
    task automatic step(input logic sq, input string tag);
        squash = sq;
        apply();
        @(negedge clock);
        check({tag, "_ready"}, 64'(bus.fu_ready), 64'(model_ready()));
        model_edge(sq);
        @(posedge clock);
        #1;
        check_outputs(tag);
        squash = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 64'(bus.cdb_out_valid), 64'(0));
        check({tag, "_noout"}, 64'(bus.cdb_ex_no_output), 64'(1));
        check({tag, "_pkt"}, 64'(bus.cdb_ex_packet), 64'(0));
        check({tag, "_ready"}, 64'(bus.fu_ready), 64'(4'hF));
`ifdef CDB_ARB_STATS_EN
        check({tag, "_stall"}, 64'(bus.stall_cycles), 64'(0));
        check({tag, "_gcnt"}, 64'(bus.grant_count), 64'(0));
`endif
    endtask

    initial begin
        reset = 1'b1;
        squash = 1'b0;
        drv_v = '0;
        drv_no = '0;
        for (int i = 0; i < NUM_FU; i++) drv_pkt[i] = '0;
        apply();
        model_reset();
        #12 reset = 1'b0;
        @(posedge clock);
        #1;
        check_reset_values("rst");

        // Single FU result: dest 5, alu_result 0x1234
        drv_v = 4'b0001; drv_no = '0;
        drv_pkt[0] = '{rob_idx: 6'd1, dest: 5'd5, alu_result: 32'h1234};
        step(1'b0, "single_push");
        drv_v = '0;
        step(1'b0, "single_bcast");
        check("single_valid", 64'(bus.cdb_out_valid), 64'(1));
        check("single_alu", 64'(bus.cdb_ex_packet.alu_result), 64'(32'h1234));
        check("single_dest", 64'(bus.cdb_ex_packet.dest), 64'(5));
        check("single_noout", 64'(bus.cdb_ex_no_output), 64'(0));
        step(1'b0, "single_idle");
        check("single_idle_valid", 64'(bus.cdb_out_valid), 64'(0));
        check("single_idle_noout", 64'(bus.cdb_ex_no_output), 64'(1));

        // Squash on an idle bus brings the round-robin pointer back to 0
        step(1'b1, "sq0");

        // Contention: all four FUs push together, grants come out 0,1,2,3
        drv_v = 4'b1111;
        for (int i = 0; i < NUM_FU; i++) new_pkt(i);
        step(1'b0, "cont_push");
        drv_v = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            step(1'b0, "cont");
            check("cont_order", 64'(bus.cdb_ex_packet.dest), 64'(k));
        end
        // Pointer back at 0: FU0 beats FU3
        drv_v = 4'b1001;
        new_pkt(0); new_pkt(3);
        step(1'b0, "rr_push");
        drv_v = '0;
        step(1'b0, "rr_a");
        check("rr_first", 64'(bus.cdb_ex_packet.dest), 64'(0));
        step(1'b0, "rr_b");
        check("rr_second", 64'(bus.cdb_ex_packet.dest), 64'(3));

        // Back-pressure: FU0..FU2 fed every cycle, FUs hold unaccepted packets
        drv_v = 4'b0111;
        for (int i = 0; i < 3; i++) new_pkt(i);
        for (int c = 0; c < 14; c++) begin
            step(1'b0, "bp");
            for (int i = 0; i < 3; i++) if (accepted[i]) new_pkt(i);
        end
        drv_v = '0;
        for (int c = 0; c < 8; c++) step(1'b0, "bp_drain");

        // Store-type completion from FU1
        drv_v = 4'b0010; drv_no = 4'b0010;
        new_pkt(1);
        step(1'b0, "noout_push");
        drv_v = '0; drv_no = '0;
        step(1'b0, "noout_bcast");
        check("noout_valid", 64'(bus.cdb_out_valid), 64'(1));
        check("noout_flag", 64'(bus.cdb_ex_no_output), 64'(1));

        // Squash with three packets queued and new pushes at the same edge
        drv_v = 4'b1111;
        for (int i = 0; i < NUM_FU; i++) new_pkt(i);
        step(1'b0, "sq_fill");
        drv_v = '0;
        step(1'b0, "sq_pop1");
        drv_v = 4'b1111;
        for (int i = 0; i < NUM_FU; i++) new_pkt(i);
        step(1'b1, "sq");
        check("sq_ready", 64'(bus.fu_ready), 64'(4'hF));
        check("sq_valid", 64'(bus.cdb_out_valid), 64'(0));
        check("sq_noout", 64'(bus.cdb_ex_no_output), 64'(1));
        drv_v = '0;
        for (int c = 0; c < 3; c++) begin
            step(1'b0, "sq_after");
            check("sq_after_valid", 64'(bus.cdb_out_valid), 64'(0));
        end

        // Random traffic with holding FUs and occasional squash
        drv_v = '0;
        for (int c = 0; c < 500; c++) begin
            logic sq;
            for (int i = 0; i < NUM_FU; i++) begin
                if (!drv_v[i] || accepted[i]) begin
                    drv_v[i]  = ($urandom_range(0, 2) != 0);
                    drv_no[i] = ($urandom_range(0, 3) == 0);
                    new_pkt(i);
                end
            end
            sq = ($urandom_range(0, 49) == 0);
            step(sq, "rnd");
        end

        // Asynchronous reset pulse between edges while traffic is pending
        drv_v = 4'b1111;
        for (int i = 0; i < NUM_FU; i++) new_pkt(i);
        step(1'b0, "ar_push");
        step(1'b0, "ar_run");
        #2 reset = 1'b1;
        #1;
        check_reset_values("arst");
        model_reset();
        #1 reset = 1'b0;
        drv_v = '0;
        for (int c = 0; c < 3; c++) step(1'b0, "ar_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
